// File: rtl/uart_tx.sv
// UART transmitter: one-word holding buffer feeding a start/data/stop serialiser.
// Every bit is held for DIVISOR clocks, and a buffered word follows the previous frame with no idle gap.
module uart_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIVISOR   = 86,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(DIVISOR - 1);
  localparam logic [IdxW-1:0] DataLast = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full_q;
  logic             ready_q;
  logic             tx_q;
  logic             busy_q;

  logic             accept;
  logic             bit_end;
  logic             frame_end;
  logic             load;
  logic [WIDTH-1:0] shift_nx;

  always_comb begin
    accept    = i_data_valid & ready_q;
    bit_end   = (cnt_q == CntMax);
    frame_end = (state_q == StStop) & bit_end & (idx_q == StopLast);
    // The buffer moves into the shift register when idle, or on the last stop cycle.
    load      = buf_full_q & ((state_q == StIdle) | frame_end);
    shift_nx  = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (load) begin
        shift_q    <= buf_q;
        buf_full_q <= 1'b0;
      end else if (accept) begin
        buf_q      <= i_data;
        buf_full_q <= 1'b1;
      end
      ready_q <= load | (~buf_full_q & ~accept);

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (load) begin
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= shift_nx;
            if (idx_q == DataLast) begin
              idx_q   <= '0;
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shift_nx[0];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == StopLast) begin
              idx_q <= '0;
              if (load) begin
                state_q <= StStart;
                tx_q    <= 1'b0;
              end else begin
                state_q <= StIdle;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle line-level queue model checks every output each cycle,
// backed by hand-computed frame patterns and lengths.
module tb_uart_tx;

  localparam int Div = 86;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       o_ready, o_tx, o_busy;
  logic [7:0] d2;
  logic       v2, r2, tx2, b2;

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(8), .DIVISOR(Div), .STOP_BITS(1)) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy)
  );

  uart_tx #(.WIDTH(8), .DIVISOR(Div), .STOP_BITS(2)) dut2 (
    .clk(clk), .i_reset(i_reset), .i_data(d2), .i_data_valid(v2),
    .o_ready(r2), .o_tx(tx2), .o_busy(b2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the line level for every remaining cycle of the current frame, plus the buffer.
  logic       m_q[$];
  bit         m_full;
  logic [7:0] m_buf;
  bit         m_ready;
  bit         m_acc;
  logic       m_lv;
  bit         cmp_en = 1'b0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_q.delete();
      m_full  = 1'b0;
      m_ready = 1'b0;
    end else begin
      m_acc = i_data_valid && m_ready;
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0 && m_full) begin
        for (int b = 0; b < 10; b++) begin
          m_lv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_buf[b-1];
          repeat (Div) m_q.push_back(m_lv);
        end
        m_full = 1'b0;
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_buf  = i_data;
      end
      m_ready = !m_full;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      check("tx", o_tx, (m_q.size() > 0) ? m_q[0] : 1'b1);
      check("busy", o_busy, m_q.size() > 0);
      check("ready", o_ready, m_ready);
    end
  end

  // Length of the most recent busy run on the main DUT.
  int run = 0;
  int last_len = 0;
  always begin
    @(posedge clk);
    #1;
    if (o_busy === 1'b1) run++;
    else begin
      if (run != 0) last_len = run;
      run = 0;
    end
  end

  // Two-stop-bit instance: 0x81 frame length and number of high cycles while busy.
  int run2 = 0;
  int ones2 = 0;
  bit done2 = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (b2 === 1'b1) begin
      run2++;
      if (tx2 === 1'b1) ones2++;
    end else if (run2 != 0) begin
      check("f2_len", run2, 946);
      check("f2_ones", ones2, 344);
      done2 = 1'b1;
      run2  = 0;
      ones2 = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, n < bound, 1);
    tick();
  endtask

  logic [9:0] a5_exp;

  initial begin
    i_reset = 1'b1; i_data_valid = 1'b0; i_data = '0; v2 = 1'b0; d2 = '0;
    a5_exp = 10'b11_0100_1010;
    repeat (3) tick();
    cmp_en = 1'b1;
    check("rst_ready", o_ready, 0);
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    i_reset = 1'b0;
    tick();
    check("release_ready", o_ready, 1);

    // Single 0xA5 frame; 0x81 on the two-stop-bit instance in parallel.
    i_data = 8'hA5; i_data_valid = 1'b1; d2 = 8'h81; v2 = 1'b1;
    tick();
    i_data_valid = 1'b0; v2 = 1'b0;
    check("lat_accept_edge", o_tx, 1);
    tick();
    check("lat_next_edge", o_tx, 0);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 43 : Div) tick();
      check($sformatf("a5_bit%0d", b), o_tx, a5_exp[b]);
    end
    wait_idle("a5", 200);
    check("a5_len", last_len, 860);

    // Held valid: 0x00 then 0xFF back to back.
    i_data = 8'h00; i_data_valid = 1'b1;
    tick();
    i_data = 8'hFF;
    tick();
    tick();
    i_data_valid = 1'b0;
    check("b2b_ready_full", o_ready, 0);
    wait_idle("b2b", 2000);
    check("b2b_len", last_len, 1720);

    // 0x3C buffered behind 0x11 while valid stays high with other data.
    i_data = 8'h11; i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    tick();
    i_data = 8'h3C; i_data_valid = 1'b1;
    tick();
    i_data = 8'hE7;
    repeat (200) tick();
    check("full_ready", o_ready, 0);
    i_data_valid = 1'b0;
    wait_idle("buf", 2000);
    check("buf_len", last_len, 1720);

    // Reset during data bit 4 of 0x5A with 0xC3 buffered; valid during reset is ignored.
    i_data = 8'h5A; i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    tick();
    i_data = 8'hC3; i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    repeat (5 * Div + 18) tick();
    check("pre_rst_busy", o_busy, 1);
    i_reset = 1'b1; i_data = 8'h77; i_data_valid = 1'b1;
    tick();
    check("mid_rst_tx", o_tx, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_ready, 0);
    i_reset = 1'b0; i_data_valid = 1'b0;
    tick();
    check("post_rst_ready", o_ready, 1);
    repeat (2000) tick();
    check("no_resume_busy", o_busy, 0);
    check("no_resume_tx", o_tx, 1);

    // Random words offered back to back.
    for (int i = 0; i < 12; i++) begin
      int n;
      bit acc;
      i_data = 8'($urandom);
      i_data_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 3000) begin
        acc = (o_ready === 1'b1);
        tick();
        n++;
      end
      check("rand_accept", acc, 1);
    end
    i_data_valid = 1'b0;
    wait_idle("rand", 3000);
    check("rand_len", last_len, 12 * 860);

    check("f2_done", done2, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame (1..16).
REQ-002 Parameter DIVISOR, default 86, clk cycles per bit (>=2; 86 = 10 MHz / 115200 baud).
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_data  input  WIDTH  word to transmit; sampled only on an accept edge.
REQ-007 i_data_valid  input  1  i_data holds a word for transmission.
REQ-008 o_ready  output  1  holding buffer empty; block accepts a word this cycle.
REQ-009 o_tx  output  1  serial line, idle high; drives uart_rx i_rx.
REQ-010 o_busy  output  1  frame in progress (start bit through last stop bit).

Function
REQ-011 Frame SHALL be: one start bit (0), WIDTH data bits LSB first, STOP_BITS stop bits (1).
REQ-012 Every bit SHALL hold on o_tx for exactly DIVISOR clk cycles; frame length = DIVISOR*(1+WIDTH+STOP_BITS) cycles.
REQ-013 Accept SHALL occur at a rising edge where i_data_valid && o_ready; i_data is then copied into a one-word holding buffer.
REQ-014 o_ready SHALL be 1 exactly when the holding buffer is empty and i_reset is low; it is a registered output.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: o_tx=1, o_busy=0; if buffer full at an edge, move buffer to shift register, empty buffer, go to START.
REQ-017 START: o_tx=0 for DIVISOR cycles, then DATA with bit index 0.
REQ-018 DATA: o_tx = shift-register bit at the current index; after DIVISOR cycles, increment index; after bit WIDTH-1, go to STOP.
REQ-019 STOP: o_tx=1 for DIVISOR*STOP_BITS cycles; on the final cycle, if buffer full, load it and go to START (no idle gap), else go to IDLE.
REQ-020 Latency: a word accepted at edge E while IDLE SHALL produce o_tx=0 starting after edge E+1.
REQ-021 o_ready SHALL rise after the edge at which the buffer transfers to the shift register; a new word may be accepted during the current frame.
REQ-022 While the buffer is full, i_data_valid SHALL be ignored and i_data SHALL not affect o_tx; a held valid is accepted exactly once.
REQ-023 Bit-period counter SHALL be $clog2(DIVISOR) bits wide, count 0..DIVISOR-1 and wrap with no drift across frames.
REQ-024 o_busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-025 o_tx SHALL be driven from a flip-flop (glitch-free).

Reset
REQ-026 On a rising edge with i_reset=1: state IDLE, o_tx=1, o_busy=0, buffer emptied, counters and index cleared; o_ready=0 while i_reset is high, 1 on the first edge after release.
REQ-027 Reset mid-frame SHALL abort the frame (o_tx=1 after that edge) and discard any buffered word; no partial frame resumes.
REQ-028 i_data_valid during reset SHALL be ignored.

Verification
REQ-029 WIDTH=8, DIVISOR=86, i_data=8'hA5 accepted once -> o_tx runs 0,1,0,1,0,0,1,0,1,1, each 86 cycles (860 total), then idles high; o_busy high for exactly 860 cycles.
REQ-030 i_data_valid held high with 8'h00 then 8'hFF -> two frames totalling 1720 consecutive cycles, no idle cycle between them; each word accepted exactly once.
REQ-031 Buffer full during a frame, i_data_valid high with 8'h3C -> o_ready=0 until the next frame loads; 8'h3C transmitted once.
REQ-032 i_reset pulsed during bit 4 of 8'h5A, with a second word buffered -> o_tx=1 after the reset edge, o_busy=0, o_ready=1 after release, nothing more transmitted.
REQ-033 STOP_BITS=2, DIVISOR=86, 8'h81 -> stop interval 172 cycles, frame 946 cycles.
REQ-034 Loopback into uart_rx (same WIDTH/DIVISOR, SAMPLE_PHASE=43), 1024 random words back-to-back -> received sequence equals transmitted sequence, zero errors.
